// File: rtl/dma_io_endpoint.sv
// Peripheral-side 8237-style DMA endpoint: DREQ/DACK handshake, IOR_N/IOW_N strobes, byte FIFO.
// Optional terminal-count EOP generation is enabled by defining DMA_EP_TERMCOUNT_EN.
module dma_io_endpoint #(
  parameter int DATA_W      = 8,
  parameter int DEPTH       = 16,
  parameter int DEMAND_MODE = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    dir,
  output logic                    DREQ,
  input  logic                    DACK,
  input  logic                    IOR_N,
  input  logic                    IOW_N,
  input  logic                    EOP_N,
  input  logic [DATA_W-1:0]       DB_IN,
  output logic [DATA_W-1:0]       DB_OUT,
  output logic                    DB_OE,
  input  logic                    wr_valid,
  input  logic [DATA_W-1:0]       wr_data,
  output logic                    wr_ready,
  output logic                    rd_valid,
  output logic [DATA_W-1:0]       rd_data,
  input  logic                    rd_ready,
  output logic                    done,
`ifdef DMA_EP_TERMCOUNT_EN
  input  logic [15:0]             term_len,
  output logic                    EOP_DRV_N,
`endif
  output logic [$clog2(DEPTH):0]  fifo_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, REQ, XFER, RELEASE} state_t;

  state_t              state, state_nxt;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic [AW-1:0]       wr_ptr, rd_ptr;
  logic [CW-1:0]       cnt, cnt_nxt;
  logic                full, empty, dir_q, dir_chg;
  logic                ior_low_p1, iow_low_p1;
  logic [DATA_W-1:0]   db_cap_p1;
  logic                cmpl, push, pop;
  logic [DATA_W-1:0]   push_data;
  logic                need, need_nxt, eop_evt, term, tc_hit;

  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  assign dir_chg = (dir != dir_q);

  // A strobe completes on its rising edge, qualified by DACK.
  assign cmpl      = DACK & (dir ? (iow_low_p1 & IOW_N) : (ior_low_p1 & IOR_N));
  assign push      = dir ? (cmpl & ~full) : (wr_valid & ~full);
  assign pop       = dir ? (rd_ready & ~empty) : (cmpl & ~empty);
  assign push_data = dir ? db_cap_p1 : wr_data;
  assign cnt_nxt   = dir_chg ? '0 : (cnt + CW'(push) - CW'(pop));

  assign need     = enable & ~term & (dir ? ~full : ~empty);
  assign need_nxt = enable & ~term & ~eop_evt &
                    (dir ? (cnt_nxt != CW'(DEPTH)) : (cnt_nxt != '0));
  assign eop_evt  = (~EOP_N & DACK) | tc_hit;

  assign wr_ready = ~full & ~dir;
  assign rd_valid = ~empty & dir;
  assign rd_data  = mem[rd_ptr];
  assign DB_OUT   = mem[rd_ptr];
  assign fifo_cnt = cnt;
  // Bus drive follows the strobe combinationally; reset releases it immediately.
  assign DB_OE    = rst_n & DACK & ~IOR_N & ~dir;

  // Strobe sampling stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ior_low_p1 <= 1'b0;
      iow_low_p1 <= 1'b0;
    end else begin
      ior_low_p1 <= ~IOR_N;
      iow_low_p1 <= ~IOW_N;
    end
  end

  always_ff @(posedge clk) begin
    if (!IOW_N) db_cap_p1 <= DB_IN;
  end

  // FIFO control
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      dir_q  <= 1'b0;
    end else begin
      dir_q <= dir;
      cnt   <= cnt_nxt;
      if (dir_chg) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push && !dir_chg) mem[wr_ptr] <= push_data;
  end

`ifdef DMA_EP_TERMCOUNT_EN
  logic [15:0] byte_cnt;
  logic        eop_drv;

  assign tc_hit    = cmpl & ((byte_cnt + 16'd1) == term_len);
  assign EOP_DRV_N = ~eop_drv;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt <= '0;
      eop_drv  <= 1'b0;
    end else begin
      eop_drv <= tc_hit;
      if (!enable)   byte_cnt <= '0;
      else if (cmpl) byte_cnt <= byte_cnt + 16'd1;
    end
  end
`else
  assign tc_hit = 1'b0;
`endif

  // Handshake state and registered request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      DREQ  <= 1'b0;
      term  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      DREQ  <= (state_nxt == REQ) || (state_nxt == XFER);
      done  <= eop_evt & ~term;
      if (!enable)      term <= 1'b0;
      else if (eop_evt) term <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (need) state_nxt = REQ;
      REQ: begin
        if (DACK)       state_nxt = XFER;
        else if (!need) state_nxt = IDLE;
      end
      XFER: begin
        if (cmpl)       state_nxt = ((DEMAND_MODE != 0) && need_nxt) ? XFER : RELEASE;
        else if (!DACK) state_nxt = need ? REQ : IDLE;
      end
      RELEASE: if (!DACK) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    // Termination overrides whatever the handshake was doing.
    if (eop_evt) state_nxt = RELEASE;
  end

endmodule

// File: tb/tb_dma_io_endpoint.sv
// Bench for dma_io_endpoint: a single-mode 16-deep and a demand-mode 4-deep instance share stimulus
// and are checked against queue models. Terminal-count checks compile only with DMA_EP_TERMCOUNT_EN.
module tb_dma_io_endpoint;

  logic       clk, rst_n, enable, dir, dack, ior_n, iow_n, eop_n, wr_valid, rd_ready;
  logic [7:0] db_in, wr_data;
  logic       dreq_s, dreq_d, db_oe_s, db_oe_d, wr_ready_s, wr_ready_d;
  logic       rd_valid_s, rd_valid_d, done_s, done_d;
  logic [7:0] db_out_s, db_out_d, rd_data_s, rd_data_d;
  logic [4:0] fifo_cnt_s;
  logic [2:0] fifo_cnt_d;
`ifdef DMA_EP_TERMCOUNT_EN
  logic [15:0] term_len;
  logic        eop_drv_n_s, eop_drv_n_d;
`endif

  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] q_s[$];
  logic [7:0] q_d[$];
  logic [7:0] wbuf[4];

  dma_io_endpoint #(.DATA_W(8), .DEPTH(16), .DEMAND_MODE(0)) dut_s (
    .clk(clk), .rst_n(rst_n), .enable(enable), .dir(dir), .DREQ(dreq_s), .DACK(dack),
    .IOR_N(ior_n), .IOW_N(iow_n), .EOP_N(eop_n), .DB_IN(db_in), .DB_OUT(db_out_s),
    .DB_OE(db_oe_s), .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready_s),
    .rd_valid(rd_valid_s), .rd_data(rd_data_s), .rd_ready(rd_ready), .done(done_s),
`ifdef DMA_EP_TERMCOUNT_EN
    .term_len(term_len), .EOP_DRV_N(eop_drv_n_s),
`endif
    .fifo_cnt(fifo_cnt_s));

  dma_io_endpoint #(.DATA_W(8), .DEPTH(4), .DEMAND_MODE(1)) dut_d (
    .clk(clk), .rst_n(rst_n), .enable(enable), .dir(dir), .DREQ(dreq_d), .DACK(dack),
    .IOR_N(ior_n), .IOW_N(iow_n), .EOP_N(eop_n), .DB_IN(db_in), .DB_OUT(db_out_d),
    .DB_OE(db_oe_d), .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready_d),
    .rd_valid(rd_valid_d), .rd_data(rd_data_d), .rd_ready(rd_ready), .done(done_d),
`ifdef DMA_EP_TERMCOUNT_EN
    .term_len(term_len), .EOP_DRV_N(eop_drv_n_d),
`endif
    .fifo_cnt(fifo_cnt_d));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $fatal(1, "timeout: bench did not reach its summary");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Queue model: acceptance and pop eligibility are judged on the occupancy before the cycle.
  task automatic mdl(input bit do_push, input logic [7:0] v, input bit do_pop);
    bit ps, pp, ds, dp;
    ps = do_push && (q_s.size() < 16);
    pp = do_pop  && (q_s.size() > 0);
    ds = do_push && (q_d.size() < 4);
    dp = do_pop  && (q_d.size() > 0);
    if (pp) void'(q_s.pop_front());
    if (ps) q_s.push_back(v);
    if (dp) void'(q_d.pop_front());
    if (ds) q_d.push_back(v);
  endtask

  task automatic check_cnt(input string tag);
    check_eq({tag, "_cnt_s"}, 32'(fifo_cnt_s), q_s.size());
    check_eq({tag, "_cnt_d"}, 32'(fifo_cnt_d), q_d.size());
  endtask

  task automatic local_push(input logic [7:0] v);
    check_eq("wr_ready_s", 32'(wr_ready_s), 32'(q_s.size() < 16));
    check_eq("wr_ready_d", 32'(wr_ready_d), 32'(q_d.size() < 4));
    wr_valid = 1'b1;
    wr_data  = v;
    @(negedge clk);
    wr_valid = 1'b0;
    mdl(1'b1, v, 1'b0);
    check_cnt("push");
  endtask

  task automatic local_pop();
    check_eq("rd_valid_s", 32'(rd_valid_s), 32'(q_s.size() > 0));
    check_eq("rd_valid_d", 32'(rd_valid_d), 32'(q_d.size() > 0));
    if (q_s.size() > 0) check_eq("rd_data_s", 32'(rd_data_s), 32'(q_s[0]));
    if (q_d.size() > 0) check_eq("rd_data_d", 32'(rd_data_d), 32'(q_d[0]));
    rd_ready = 1'b1;
    @(negedge clk);
    rd_ready = 1'b0;
    mdl(1'b0, 8'h00, 1'b1);
    check_cnt("pop");
  endtask

  task automatic wait_dreq_s();
    for (int k = 0; k < 40 && !dreq_s; k++) @(negedge clk);
    check_eq("dreq_s_wait", 32'(dreq_s), 32'd1);
  endtask

  task automatic wait_dreq_d();
    for (int k = 0; k < 40 && !dreq_d; k++) @(negedge clk);
    check_eq("dreq_d_wait", 32'(dreq_d), 32'd1);
  endtask

  // One controller read cycle (dir=0): DACK, IOR_N low for one clock, release.
  task automatic dma_rd(input bit eop, input bit exp_done, input bit also_push);
    logic [7:0] v;
    wait_dreq_s();
    check_eq("dreq_d_pre", 32'(dreq_d), 32'd1);
    dack = 1'b1;
    @(negedge clk);
    check_eq("db_oe_dack_only", 32'(db_oe_s), 32'd0);
    ior_n = 1'b0;
    @(negedge clk);
    check_eq("db_oe_s", 32'(db_oe_s), 32'd1);
    check_eq("db_oe_d", 32'(db_oe_d), 32'd1);
    check_eq("db_out_s", 32'(db_out_s), 32'(q_s[0]));
    check_eq("db_out_d", 32'(db_out_d), 32'(q_d[0]));
    v = 8'($urandom);
    ior_n = 1'b1;
    eop_n = !eop;
    if (also_push) begin
      wr_valid = 1'b1;
      wr_data  = v;
    end
    @(negedge clk);
    mdl(also_push, v, 1'b1);
    check_cnt("rd");
    check_eq("dreq_s_post", 32'(dreq_s), 32'd0);
    check_eq("dreq_d_post", 32'(dreq_d), 32'(!exp_done && (q_d.size() > 0)));
    check_eq("done_s", 32'(done_s), 32'(exp_done));
    check_eq("done_d", 32'(done_d), 32'(exp_done));
`ifdef DMA_EP_TERMCOUNT_EN
    check_eq("eop_drv_s", 32'(eop_drv_n_s), 32'(!(exp_done && !eop)));
    check_eq("eop_drv_d", 32'(eop_drv_n_d), 32'(!(exp_done && !eop)));
`endif
    eop_n    = 1'b1;
    wr_valid = 1'b0;
    dack     = 1'b0;
    @(negedge clk);
    check_eq("done_once", 32'(done_s), 32'd0);
    check_eq("dreq_s_gap", 32'(dreq_s), 32'd0);
`ifdef DMA_EP_TERMCOUNT_EN
    check_eq("eop_drv_rel", 32'(eop_drv_n_s), 32'd1);
`endif
  endtask

  // Controller write burst (dir=1) with DACK held across n IOW_N strobes.
  task automatic dma_wr_burst(input int n, input bit pop_too);
    bit pop_now;
    wait_dreq_d();
    check_eq("dreq_s_pre", 32'(dreq_s), 32'd1);
    dack = 1'b1;
    @(negedge clk);
    for (int i = 0; i < n; i++) begin
      iow_n = 1'b0;
      db_in = wbuf[i];
      @(negedge clk);
      iow_n   = 1'b1;
      db_in   = 8'($urandom);
      pop_now = pop_too && (q_s.size() > 0);
      if (pop_now) begin
        check_eq("rd_data_mid_s", 32'(rd_data_s), 32'(q_s[0]));
        check_eq("rd_data_mid_d", 32'(rd_data_d), 32'(q_d[0]));
        rd_ready = 1'b1;
      end
      @(negedge clk);
      rd_ready = 1'b0;
      mdl(1'b1, wbuf[i], pop_now);
      check_cnt("wr");
      check_eq("dreq_d_burst", 32'(dreq_d), 32'(q_d.size() < 4));
      check_eq("dreq_s_burst", 32'(dreq_s), 32'd0);
    end
    dack = 1'b0;
    @(negedge clk);
  endtask

  task automatic set_dir(input bit d);
    enable = 1'b0;
    @(negedge clk);
    dir = d;
    @(negedge clk);
    q_s.delete();
    q_d.delete();
    check_cnt("flush");
    enable = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; dir = 1'b0; dack = 1'b0; ior_n = 1'b1; iow_n = 1'b1;
    eop_n = 1'b1; db_in = '0; wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;
`ifdef DMA_EP_TERMCOUNT_EN
    term_len = 16'd0;
`endif
    repeat (3) @(negedge clk);
    check_eq("rst_dreq_s", 32'(dreq_s), 32'd0);
    check_eq("rst_dreq_d", 32'(dreq_d), 32'd0);
    check_eq("rst_done", 32'(done_s), 32'd0);
    check_eq("rst_db_oe", 32'(db_oe_s), 32'd0);
    check_cnt("rst");
    rst_n = 1'b1;
    @(negedge clk);
    enable = 1'b1;

    // Single-mode peripheral->memory transfer of three bytes
    local_push(8'hA1);
    local_push(8'hB2);
    local_push(8'hC3);
    repeat (3) dma_rd(1'b0, 1'b0, 1'b0);
    check_cnt("t1_end");

    // Changing dir discards queued data
    local_push(8'($urandom));
    local_push(8'($urandom));
    set_dir(1'b1);

    // Demand-mode memory->peripheral burst until full
    wbuf = '{8'h10, 8'h20, 8'h30, 8'h40};
    dma_wr_burst(4, 1'b0);
    repeat (4) local_pop();

    // EOP coinciding with a strobe completion
    set_dir(1'b0);
    local_push(8'h5A);
    local_push(8'h6B);
    dma_rd(1'b1, 1'b1, 1'b0);
    repeat (5) @(negedge clk);
    check_eq("term_hold_s", 32'(dreq_s), 32'd0);
    check_eq("term_hold_d", 32'(dreq_d), 32'd0);
    enable = 1'b0;
    @(negedge clk);
    enable = 1'b1;

    // Preemption: DACK withdrawn in XFER without a strobe
    wait_dreq_s();
    dack = 1'b1;
    @(negedge clk);
    check_eq("xfer_dreq", 32'(dreq_s), 32'd1);
    dack = 1'b0;
    @(negedge clk);
    check_eq("preempt_dreq_s", 32'(dreq_s), 32'd1);
    check_eq("preempt_dreq_d", 32'(dreq_d), 32'd1);
    check_cnt("preempt");
    dma_rd(1'b0, 1'b0, 1'b0);

    // Randomized traffic in both directions
    for (int r = 0; r < 6; r++) begin
      int k;
      k = $urandom_range(1, 3);
      for (int j = 0; j < k; j++) local_push(8'($urandom));
      for (int j = 0; j < k; j++) dma_rd(1'b0, 1'b0, (j == 0) ? 1'($urandom % 2) : 1'b0);
      for (int g = 0; g < 8 && q_s.size() > 0; g++) dma_rd(1'b0, 1'b0, 1'b0);
      set_dir(1'b1);
      k = $urandom_range(1, 4);
      for (int j = 0; j < 4; j++) wbuf[j] = 8'($urandom);
      dma_wr_burst(k, 1'($urandom % 2));
      for (int g = 0; g < 8 && q_s.size() > 0; g++) local_pop();
      set_dir(1'b0);
    end

    // Asynchronous reset in the middle of a transfer
    for (int j = 0; j < 5; j++) local_push(8'($urandom));
    wait_dreq_s();
    dack = 1'b1;
    @(negedge clk);
    ior_n = 1'b0;
    @(negedge clk);
    check_eq("pre_rst_db_oe", 32'(db_oe_s), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    q_s.delete();
    q_d.delete();
    check_eq("arst_dreq_s", 32'(dreq_s), 32'd0);
    check_eq("arst_dreq_d", 32'(dreq_d), 32'd0);
    check_eq("arst_db_oe_s", 32'(db_oe_s), 32'd0);
    check_eq("arst_db_oe_d", 32'(db_oe_d), 32'd0);
    check_cnt("arst");
    @(negedge clk);
    dack  = 1'b0;
    ior_n = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

`ifdef DMA_EP_TERMCOUNT_EN
    // Terminal count of two bytes with four queued
    term_len = 16'd2;
    for (int j = 0; j < 4; j++) local_push(8'($urandom));
    dma_rd(1'b0, 1'b0, 1'b0);
    dma_rd(1'b0, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    check_eq("tc_hold_dreq", 32'(dreq_s), 32'd0);
    check_cnt("tc_end");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
